// File: rtl/rv32v_vreg_wb_buffer.sv
// rv32v_vreg_wb_buffer
// -----------------------------------------------------------------------------
// Write-back staging buffer between the vector ROB commit port and the vector
// register file write port. Committed writes are queued in order in a small
// FIFO and drained one per cycle when the VRF grants its write port.
//
// Each queued entry holds a destination register and a bit-granular write
// mask with matching data. A full-register ROB write turns its byte enables
// into a bit mask. A single-bit mask write becomes a one-hot mask, with its
// data bit at the same position.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   rob_wen_i/vd/byte_en/wdata  committed full-register write
//   sb_wen_i/vd/idx/bit     committed single-bit mask write
//   full_o                  commit must stall (fewer than two free slots)
//   empty_o, count_o        occupancy
//   overflow_o              sticky: a write arrived with no free slot
//   vrf_wen_o/vd/wmask/wdata  head entry presented to the VRF
//   vrf_ready_i             VRF accepts the head entry this cycle
//   lookup_vs1_i/vs2_i      decode source registers
//   pend_hit1_o/hit2_o      a queued entry targets the looked-up register
// -----------------------------------------------------------------------------
module rv32v_vreg_wb_buffer #(
   parameter int DEPTH = 4,
   parameter int VLEN  = 128
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      rob_wen_i,
   input  logic [4:0]                rob_vd_i,
   input  logic [VLEN/8-1:0]         rob_byte_en_i,
   input  logic [VLEN-1:0]           rob_wdata_i,
   input  logic                      sb_wen_i,
   input  logic [4:0]                sb_vd_i,
   input  logic [$clog2(VLEN)-1:0]   sb_idx_i,
   input  logic                      sb_bit_i,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      overflow_o,
   output logic                      vrf_wen_o,
   output logic [4:0]                vrf_vd_o,
   output logic [VLEN-1:0]           vrf_wmask_o,
   output logic [VLEN-1:0]           vrf_wdata_o,
   input  logic                      vrf_ready_i,
   input  logic [4:0]                lookup_vs1_i,
   input  logic [4:0]                lookup_vs2_i,
   output logic                      pend_hit1_o,
   output logic                      pend_hit2_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]      vd_q    [DEPTH];
   logic [VLEN-1:0] wmask_q [DEPTH];
   logic [VLEN-1:0] wdata_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic [VLEN-1:0] rob_wmask;
   logic [VLEN-1:0] sb_wmask;
   logic [VLEN-1:0] sb_wdata;
   logic [CW-1:0]   free_slots;
   logic [CW-1:0]   sb_need;
   logic            deq;
   logic            rob_accept;
   logic            sb_accept;
   logic [PW-1:0]   sb_slot;

   // Expand the ROB byte enables into a bit mask: every bit of byte b
   // follows rob_byte_en_i[b].
   always_comb begin
      rob_wmask = '0;
      for (int i = 0; i < VLEN; i++) begin
         rob_wmask[i] = rob_byte_en_i[i/8];
      end
   end

   // A mask write touches exactly one bit. All other data bits are zero,
   // so the VRF sees a clean one-hot update.
   assign sb_wmask = {{(VLEN-1){1'b0}}, 1'b1} << sb_idx_i;
   assign sb_wdata = {{(VLEN-1){1'b0}}, sb_bit_i} << sb_idx_i;

   // Slot accounting. A slot freed by this cycle's dequeue may be reused at
   // the same edge. On a dual write the ROB entry takes the first free slot,
   // so when only one slot is left the mask write is the one dropped.
   always_comb begin
      deq        = (count_q != '0) && vrf_ready_i;
      free_slots = DEPTH_C - count_q + CW'(deq);
      rob_accept = rob_wen_i && (free_slots != '0);
      sb_need    = rob_accept ? CW'(2) : CW'(1);
      sb_accept  = sb_wen_i && (free_slots >= sb_need);
      sb_slot    = tail_q + PW'(rob_accept);

      head_d     = deq ? head_q + PW'(1) : head_q;
      tail_d     = tail_q + PW'(rob_accept) + PW'(sb_accept);
      count_d    = count_q + CW'(rob_accept) + CW'(sb_accept) - CW'(deq);
      overflow_d = overflow_q
                   || (rob_wen_i && !rob_accept)
                   || (sb_wen_i && !sb_accept);
   end

   // Pointer, occupancy and sticky error registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage. The dequeue clear is written before the enqueue sets.
   // When a full buffer drains and refills the same slot in one cycle, the
   // new entry therefore stays valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            vd_q[i]    <= '0;
            wmask_q[i] <= '0;
            wdata_q[i] <= '0;
         end
      end else begin
         if (deq) begin
            valid_q[head_q] <= 1'b0;
         end
         if (rob_accept) begin
            valid_q[tail_q] <= 1'b1;
            vd_q[tail_q]    <= rob_vd_i;
            wmask_q[tail_q] <= rob_wmask;
            wdata_q[tail_q] <= rob_wdata_i;
         end
         if (sb_accept) begin
            valid_q[sb_slot] <= 1'b1;
            vd_q[sb_slot]    <= sb_vd_i;
            wmask_q[sb_slot] <= sb_wmask;
            wdata_q[sb_slot] <= sb_wdata;
         end
      end
   end

   // The head entry drives the VRF port. The outputs are forced to zero when
   // the buffer is empty, so stale slot contents never leak out.
   always_comb begin
      vrf_wen_o   = (count_q != '0);
      vrf_vd_o    = '0;
      vrf_wmask_o = '0;
      vrf_wdata_o = '0;
      if (vrf_wen_o) begin
         vrf_vd_o    = vd_q[head_q];
         vrf_wmask_o = wmask_q[head_q];
         vrf_wdata_o = wdata_q[head_q];
      end
   end

   // RAW lookup runs over registered entries only. An entry leaving this
   // cycle still reports a hit, and a write arriving this cycle is not yet
   // visible.
   always_comb begin
      pend_hit1_o = 1'b0;
      pend_hit2_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (vd_q[i] == lookup_vs1_i)) begin
            pend_hit1_o = 1'b1;
         end
         if (valid_q[i] && (vd_q[i] == lookup_vs2_i)) begin
            pend_hit2_o = 1'b1;
         end
      end
   end

   assign count_o    = count_q;
   assign empty_o    = (count_q == '0);
   assign full_o     = (DEPTH_C - count_q) < CW'(2);
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rv32v_vreg_wb_buffer.sv
// Testbench for rv32v_vreg_wb_buffer. A table of single-cycle vectors
// is followed by hand-written sequences: in-order wrap-around, overflow
// with the dual-write drop rule, and asynchronous reset mid-stream.
module tb_rv32v_vreg_wb_buffer;

   localparam int VLEN = 128;
   localparam logic [127:0] ONES   = {128{1'b1}};
   localparam logic [127:0] ZERO   = 128'h0;
   localparam logic [127:0] M64    = {64'h0, {64{1'b1}}};
   localparam logic [127:0] B77    = 128'd1 << 77;
   localparam logic [127:0] TOP8   = {8'hFF, 120'h0};
   localparam logic [127:0] TOPBIT = {1'b1, 127'h0};
   localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] D2 = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
   localparam logic [127:0] D3 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
   localparam logic [127:0] D4 = 128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0;

   logic          clk = 1'b0;
   logic          rstN;
   logic          robWen;
   logic [4:0]    robVd;
   logic [15:0]   robBe;
   logic [127:0]  robData;
   logic          sbWen;
   logic [4:0]    sbVd;
   logic [6:0]    sbIdx;
   logic          sbBit;
   logic          full, empty, overflow;
   logic [2:0]    count;
   logic          vrfWen;
   logic [4:0]    vrfVd;
   logic [127:0]  vrfWmask, vrfWdata;
   logic          vrfReady;
   logic [4:0]    lk1, lk2;
   logic          hit1, hit2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         robWen;
      logic [4:0]   robVd;
      logic [15:0]  robBe;
      logic [127:0] robData;
      logic         sbWen;
      logic [4:0]   sbVd;
      logic [6:0]   sbIdx;
      logic         sbBit;
      logic         ready;
      logic [4:0]   lk1;
      logic [4:0]   lk2;
      logic         expWen;
      logic [4:0]   expVd;
      logic [127:0] expMask;
      logic [127:0] expData;
      logic [2:0]   expCount;
      logic         expFull;
      logic         expEmpty;
      logic         expOvf;
      logic         expHit1;
      logic         expHit2;
   } vec_t;

   vec_t vecs[16];

   rv32v_vreg_wb_buffer #(.DEPTH(4), .VLEN(VLEN)) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .rob_wen_i     (robWen),
      .rob_vd_i      (robVd),
      .rob_byte_en_i (robBe),
      .rob_wdata_i   (robData),
      .sb_wen_i      (sbWen),
      .sb_vd_i       (sbVd),
      .sb_idx_i      (sbIdx),
      .sb_bit_i      (sbBit),
      .full_o        (full),
      .empty_o       (empty),
      .count_o       (count),
      .overflow_o    (overflow),
      .vrf_wen_o     (vrfWen),
      .vrf_vd_o      (vrfVd),
      .vrf_wmask_o   (vrfWmask),
      .vrf_wdata_o   (vrfWdata),
      .vrf_ready_i   (vrfReady),
      .lookup_vs1_i  (lk1),
      .lookup_vs2_i  (lk2),
      .pend_hit1_o   (hit1),
      .pend_hit2_o   (hit2)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard stop in case the bench itself wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic driveIdle();
      robWen = 1'b0; robVd = '0; robBe = '0; robData = '0;
      sbWen = 1'b0; sbVd = '0; sbIdx = '0; sbBit = 1'b0;
   endtask

   // Drive one vector on the falling edge, then let one rising edge pass.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      robWen = v.robWen; robVd = v.robVd; robBe = v.robBe; robData = v.robData;
      sbWen = v.sbWen; sbVd = v.sbVd; sbIdx = v.sbIdx; sbBit = v.sbBit;
      vrfReady = v.ready; lk1 = v.lk1; lk2 = v.lk2;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVector(input int i, input vec_t v);
      checkOutput($sformatf("v%0d_wen", i),   128'(vrfWen),   128'(v.expWen));
      checkOutput($sformatf("v%0d_vd", i),    128'(vrfVd),    128'(v.expVd));
      checkOutput($sformatf("v%0d_wmask", i), vrfWmask,       v.expMask);
      checkOutput($sformatf("v%0d_wdata", i), vrfWdata,       v.expData);
      checkOutput($sformatf("v%0d_count", i), 128'(count),    128'(v.expCount));
      checkOutput($sformatf("v%0d_full", i),  128'(full),     128'(v.expFull));
      checkOutput($sformatf("v%0d_empty", i), 128'(empty),    128'(v.expEmpty));
      checkOutput($sformatf("v%0d_ovf", i),   128'(overflow), 128'(v.expOvf));
      checkOutput($sformatf("v%0d_hit1", i),  128'(hit1),     128'(v.expHit1));
      checkOutput($sformatf("v%0d_hit2", i),  128'(hit2),     128'(v.expHit2));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_wen"},   128'(vrfWen),   128'(0));
      checkOutput({tag, "_vd"},    128'(vrfVd),    128'(0));
      checkOutput({tag, "_wmask"}, vrfWmask,       ZERO);
      checkOutput({tag, "_wdata"}, vrfWdata,       ZERO);
      checkOutput({tag, "_count"}, 128'(count),    128'(0));
      checkOutput({tag, "_full"},  128'(full),     128'(0));
      checkOutput({tag, "_empty"}, 128'(empty),    128'(1));
      checkOutput({tag, "_ovf"},   128'(overflow), 128'(0));
      checkOutput({tag, "_hit1"},  128'(hit1),     128'(0));
      checkOutput({tag, "_hit2"},  128'(hit2),     128'(0));
   endtask

   initial begin
      logic [4:0]   modelQ[$];
      logic [4:0]   headVd;
      logic         doWrite;
      int           nWritten;
      int           cyc;

      // Each vector lists the inputs for one cycle, followed by the outputs
      // expected just after the next rising edge.
      vecs[0]  = '{1'b1,5'd3,16'h00FF,ONES, 1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd3,5'd4,
                   1'b1,5'd3,M64,ONES,      3'd1,1'b0,1'b0,1'b0, 1'b1,1'b0};
      vecs[1]  = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd3,5'd0,
                   1'b0,5'd0,ZERO,ZERO,     3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0};
      vecs[2]  = '{1'b0,5'd0,16'h0,ZERO,    1'b1,5'd0,7'd77,1'b1, 1'b1, 5'd0,5'd7,
                   1'b1,5'd0,B77,B77,       3'd1,1'b0,1'b0,1'b0, 1'b1,1'b0};
      vecs[3]  = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd0,5'd0,
                   1'b0,5'd0,ZERO,ZERO,     3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0};
      vecs[4]  = '{1'b1,5'd1,16'hFFFF,D1,   1'b0,5'd0,7'd0,1'b0, 1'b0, 5'd1,5'd5,
                   1'b1,5'd1,ONES,D1,       3'd1,1'b0,1'b0,1'b0, 1'b1,1'b0};
      vecs[5]  = '{1'b1,5'd2,16'h0001,D2,   1'b0,5'd0,7'd0,1'b0, 1'b0, 5'd2,5'd5,
                   1'b1,5'd1,ONES,D1,       3'd2,1'b0,1'b0,1'b0, 1'b1,1'b0};
      vecs[6]  = '{1'b1,5'd3,16'h8000,D3,   1'b0,5'd0,7'd0,1'b0, 1'b0, 5'd2,5'd5,
                   1'b1,5'd1,ONES,D1,       3'd3,1'b1,1'b0,1'b0, 1'b1,1'b0};
      vecs[7]  = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b0, 5'd2,5'd5,
                   1'b1,5'd1,ONES,D1,       3'd3,1'b1,1'b0,1'b0, 1'b1,1'b0};
      vecs[8]  = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd1,5'd3,
                   1'b1,5'd2,128'hFF,D2,    3'd2,1'b0,1'b0,1'b0, 1'b0,1'b1};
      vecs[9]  = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd2,5'd3,
                   1'b1,5'd3,TOP8,D3,       3'd1,1'b0,1'b0,1'b0, 1'b0,1'b1};
      vecs[10] = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd3,5'd3,
                   1'b0,5'd0,ZERO,ZERO,     3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0};
      vecs[11] = '{1'b1,5'd4,16'hFFFF,D4,   1'b1,5'd0,7'd0,1'b0, 1'b0, 5'd4,5'd0,
                   1'b1,5'd4,ONES,D4,       3'd2,1'b0,1'b0,1'b0, 1'b1,1'b1};
      vecs[12] = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd4,5'd0,
                   1'b1,5'd0,128'h1,ZERO,   3'd1,1'b0,1'b0,1'b0, 1'b0,1'b1};
      vecs[13] = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd0,5'd0,
                   1'b0,5'd0,ZERO,ZERO,     3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0};
      vecs[14] = '{1'b0,5'd0,16'h0,ZERO,    1'b1,5'd31,7'd127,1'b1, 1'b0, 5'd31,5'd30,
                   1'b1,5'd31,TOPBIT,TOPBIT,3'd1,1'b0,1'b0,1'b0, 1'b1,1'b0};
      vecs[15] = '{1'b0,5'd0,16'h0,ZERO,    1'b0,5'd0,7'd0,1'b0, 1'b1, 5'd31,5'd0,
                   1'b0,5'd0,ZERO,ZERO,     3'd0,1'b0,1'b1,1'b0, 1'b0,1'b0};

      // Reset state.
      rstN = 1'b0;
      driveIdle();
      vrfReady = 1'b0; lk1 = '0; lk2 = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      @(negedge clk);
      rstN = 1'b1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Wrap-around: ten writes while ready toggles every cycle. Writes are
      // issued only when the model says the buffer is not full.
      nWritten = 0;
      cyc = 0;
      modelQ.delete();
      while ((nWritten < 10 || modelQ.size() > 0) && cyc < 80) begin
         @(negedge clk);
         vrfReady = (cyc % 2 == 0);
         doWrite  = (nWritten < 10) && ((4 - modelQ.size()) >= 2);
         driveIdle();
         robWen  = doWrite;
         robVd   = 5'(8 + nWritten);
         robBe   = 16'hFFFF;
         robData = {4{32'(8 + nWritten)}};
         @(posedge clk);
         #1;
         if (modelQ.size() > 0 && vrfReady) void'(modelQ.pop_front());
         if (doWrite) begin
            modelQ.push_back(5'(8 + nWritten));
            nWritten++;
         end
         headVd = (modelQ.size() > 0) ? modelQ[0] : 5'd0;
         checkOutput($sformatf("wrap%0d_count", cyc), 128'(count), 128'(modelQ.size()));
         checkOutput($sformatf("wrap%0d_wen", cyc), 128'(vrfWen), 128'(modelQ.size() > 0));
         checkOutput($sformatf("wrap%0d_vd", cyc), 128'(vrfVd), 128'(headVd));
         checkOutput($sformatf("wrap%0d_wdata", cyc), vrfWdata,
                     (modelQ.size() > 0) ? {4{32'(headVd)}} : ZERO);
         checkOutput($sformatf("wrap%0d_ovf", cyc), 128'(overflow), 128'(0));
         cyc++;
      end
      if (cyc >= 80) begin
         checks++;
         failures++;
         $display("[TB] FAIL wrap_timeout: got %0d writes expected 10", nWritten);
      end

      // Fill all four slots while the VRF is stalled.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         driveIdle();
         vrfReady = 1'b0;
         robWen = 1'b1; robVd = 5'(20 + k); robBe = 16'hFFFF; robData = 128'(k);
         @(posedge clk);
         #1;
      end
      checkOutput("fill_count", 128'(count), 128'(4));
      checkOutput("fill_full", 128'(full), 128'(1));
      checkOutput("fill_ovf", 128'(overflow), 128'(0));
      checkOutput("fill_vd", 128'(vrfVd), 128'(20));

      // A write into a full, stalled buffer is dropped and overflow sets.
      @(negedge clk);
      robVd = 5'd24; lk1 = 5'd24; lk2 = 5'd23;
      @(posedge clk);
      #1;
      checkOutput("drop_count", 128'(count), 128'(4));
      checkOutput("drop_ovf", 128'(overflow), 128'(1));
      checkOutput("drop_vd", 128'(vrfVd), 128'(20));
      checkOutput("drop_hit1", 128'(hit1), 128'(0));
      checkOutput("drop_hit2", 128'(hit2), 128'(1));

      // Dual write with exactly one slot freed by the dequeue: the ROB write
      // is kept and the mask write is dropped. The dequeuing head still hits.
      @(negedge clk);
      driveIdle();
      vrfReady = 1'b1;
      robWen = 1'b1; robVd = 5'd25; robBe = 16'hFFFF; robData = ONES;
      sbWen = 1'b1; sbVd = 5'd26; sbIdx = 7'd5; sbBit = 1'b1;
      lk1 = 5'd20; lk2 = 5'd26;
      #1;
      checkOutput("deqhit_hit1", 128'(hit1), 128'(1));
      @(posedge clk);
      #1;
      checkOutput("dual_count", 128'(count), 128'(4));
      checkOutput("dual_vd", 128'(vrfVd), 128'(21));
      checkOutput("dual_ovf", 128'(overflow), 128'(1));
      checkOutput("dual_hit1", 128'(hit1), 128'(0));
      checkOutput("dual_hit2", 128'(hit2), 128'(0));
      lk1 = 5'd25;
      #1;
      checkOutput("dual_keep", 128'(hit1), 128'(1));

      // Asynchronous reset in the middle of a cycle.
      driveIdle();
      vrfReady = 1'b0;
      lk1 = 5'd21; lk2 = 5'd22;
      rstN = 1'b0;
      #1;
      checkResetState("midrst");
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_empty", 128'(empty), 128'(1));
      checkOutput("post_ovf", 128'(overflow), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv32v_vreg_wb_buffer.md
Name: rv32v_vreg_wb_buffer

Overview:
- Write-back staging buffer between the vector reorder buffer commit port and the vector register file (VRF) write port.
- Accepts committed full-register writes (vd, 16-bit byte enables, VLEN data) and single-bit mask writes, and queues them in order in a small FIFO.
- Drains one entry per cycle when the VRF grants its write port, then presents a bit-granular write mask.
- Provides pending-write lookups so vector decode can detect RAW hazards on registers not yet written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- VLEN, 128, vector register width in bits. Byte enables are VLEN/8 = 16 bits.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- rob_wen  in  1  committed full-register write valid (ROB vreg_wen).
- rob_vd  in  5  destination register.
- rob_byte_en  in  16  per-byte write enables.
- rob_wdata  in  VLEN  write data.
- sb_wen  in  1  single-bit mask write valid.
- sb_vd  in  5  destination register of the mask write.
- sb_idx  in  $clog2(VLEN)  bit index.
- sb_bit  in  1  bit value.
- full  out  1  commit must stall; asserted when free slots < 2.
- empty  out  1  no pending entries.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky error: a write arrived while no slot was free.
- vrf_wen  out  1  VRF write request; the head entry is valid.
- vrf_vd  out  5  head destination.
- vrf_wmask  out  VLEN  bit-level write mask.
- vrf_wdata  out  VLEN  head data.
- vrf_ready  in  1  VRF accepts the write this cycle (no bank conflict).
- lookup_vs1  in  5  decode source register 1.
- lookup_vs2  in  5  decode source register 2.
- pend_hit1  out  1  some valid entry targets lookup_vs1.
- pend_hit2  out  1  some valid entry targets lookup_vs2.

Behaviour:
- Reset (async, nRST=0) clears all valid bits, head/tail pointers, count and overflow. Outputs during reset: vrf_wen=0, vrf_vd=0, vrf_wmask=0, vrf_wdata=0, full=0, empty=1, count=0, pend_hit1/2=0.
- Reset asserted mid-operation discards all queued writes. The ROB is reset in the same domain, so no write is lost architecturally.
- Entry contents: vd, wmask[VLEN], wdata[VLEN].
- Conversion of a ROB write: wmask bit i = rob_byte_en[i/8]; wdata = rob_wdata.
- Conversion of an sb write: wmask = 1<<sb_idx; wdata = sb_bit<<sb_idx, with all other data bits 0.
- Enqueue happens at the rising edge when the valid input is high. Latency is fixed at 1 cycle: a write enqueued at edge N into an empty buffer drives vrf_wen at cycle N+1. There is no combinational bypass.
- If rob_wen and sb_wen are high in the same cycle, both enqueue: the ROB entry at tail and the sb entry at tail+1, so the ROB write drains first. Tail advances by 2.
- Dequeue: when vrf_wen && vrf_ready at the edge, head advances by 1.
- Enqueue and dequeue may occur in the same cycle. Count update: count_next = count + enq_n - deq (enq_n in 0..2).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, not from pointer equality.
- full = (DEPTH - count) < 2, computed combinationally from registered count. It does not reflect the current cycle's dequeue.
- Upstream guarantee: no rob_wen or sb_wen while full.
- Overflow handling: if a write arrives with no free slot (after accounting for the same-cycle dequeue), that write is dropped and overflow sets and stays set until reset. If one slot is free during a dual write, the ROB write is kept and the sb write is dropped.
- vrf_* outputs are driven from the head entry while count > 0. They hold stable while vrf_ready=0 and are zero when empty.
- pend_hit1/2 are combinational: the OR over valid entries of (entry.vd == lookup_vsX).
  - An entry dequeuing this cycle still counts as a hit.
  - A write arriving this cycle does not count until the next cycle.
  - Decode must stall on a hit.
- No flush input: entries are architecturally committed and always drain.

Test Plan:
- Reset release, then one ROB write (vd=3, byte_en=16'h00FF, data=all-ones) with vrf_ready=1 -> next cycle vrf_wen=1, vrf_vd=3, vrf_wmask[63:0] all ones, vrf_wmask[127:64]=0; following cycle empty=1.
- sb write (vd=0, idx=77, bit=1) -> vrf_wmask=1<<77, vrf_wdata=1<<77.
- vrf_ready=0 with 3 ROB writes (vd=1,2,3) -> count=3, full=1 (DEPTH=4); vrf_vd holds 1; pend_hit1=1 for lookup_vs1=2 and pend_hit2=0 for lookup_vs2=5. Then vrf_ready=1 -> drains 1,2,3 on consecutive cycles.
- Simultaneous rob_wen (vd=4) and sb_wen (vd=0) into an empty buffer -> count=2; drains vd=4 then vd=0.
- Wrap-around: 10 single writes with vrf_ready toggling 1/0 -> in-order drain, count never exceeds 4, overflow=0.
- Force a write while count=4 and vrf_ready=0 -> write dropped, overflow=1 and stays 1; then nRST low mid-stream -> outputs reset immediately (asynchronously), overflow=0.
